// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types for the main-memory arbiter (FSM states, requesters).
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } requester_e;

  // Counter width able to hold values up to 'limit' (at least one bit).
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_timer
// Brief    : Access watchdog; expired flags the last allowed BUSY cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // A zero limit disables the watchdog entirely.
  assign o_expired = i_enable && (i_limit != '0) && (r_count == i_limit - CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares the main-memory port between I-cache refills and D-cache
//            loads/stores. Define ARB_RR_EN for round-robin arbitration,
//            otherwise the D-cache has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ic_req_i,
  input  logic [WIDTH-1:0] ic_addr_i,
  output logic             ic_done_o,
  output logic [WIDTH-1:0] ic_rdata_o,
  input  logic             dc_req_i,
  input  logic             dc_we_i,
  input  logic [WIDTH-1:0] dc_addr_i,
  input  logic [WIDTH-1:0] dc_wdata_i,
  output logic             dc_done_o,
  output logic [WIDTH-1:0] dc_rdata_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic             mem_ready_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic             timeout_o,
  output logic             busy_o
);

  import mem_arb_pkg::*;

  localparam int c_CNT_W = cnt_width(TIMEOUT_CYCLES);

  arb_state_e       r_state;
  arb_state_e       w_next_state;
  requester_e       r_owner;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic             r_we;
  logic             r_timeout;
  logic             w_any_req;
  logic             w_grant_dc;
  logic             w_grant;
  logic             w_busy;
  logic             w_resp;
  logic             w_expired;

  assign w_any_req = ic_req_i | dc_req_i;
  assign w_grant   = (r_state == IDLE) && w_any_req;
  assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_resp    = (r_state == RESP);

`ifdef ARB_RR_EN
  requester_e r_last_grant;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_grant <= REQ_IC;
    end else if (w_grant) begin
      r_last_grant <= w_grant_dc ? REQ_DC : REQ_IC;
    end
  end

  // On a tie, the requester that was not served last wins.
  assign w_grant_dc = dc_req_i && (!ic_req_i || (r_last_grant == REQ_IC));
`else
  assign w_grant_dc = dc_req_i;
`endif

  mem_arb_timer #(
    .CNT_W (c_CNT_W)
  ) u_timer (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .i_clear   (w_grant),
    .i_enable  (w_busy),
    .i_limit   (c_CNT_W'(TIMEOUT_CYCLES)),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:           if (w_any_req) w_next_state = w_grant_dc ? BUSY_D : BUSY_I;
      BUSY_I, BUSY_D: if (mem_ready_i || w_expired) w_next_state = RESP;
      RESP:           w_next_state = IDLE;
      default:        w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner   <= REQ_IC;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_we      <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_grant) begin
      r_owner <= w_grant_dc ? REQ_DC : REQ_IC;
      r_addr  <= w_grant_dc ? dc_addr_i : ic_addr_i;
      r_we    <= w_grant_dc && dc_we_i;
      r_wdata <= w_grant_dc ? dc_wdata_i : '0;
    end else if (w_busy) begin
      // A ready arriving on the final watchdog cycle still completes normally.
      if (mem_ready_i) begin
        r_rdata   <= r_we ? '0 : mem_rdata_i;
        r_timeout <= 1'b0;
      end else if (w_expired) begin
        r_rdata   <= '0;
        r_timeout <= 1'b1;
      end
    end
  end

  assign mem_req_o   = w_busy;
  assign mem_we_o    = w_busy && r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign ic_done_o   = w_resp && (r_owner == REQ_IC);
  assign dc_done_o   = w_resp && (r_owner == REQ_DC);
  assign ic_rdata_o  = ic_done_o ? r_rdata : '0;
  assign dc_rdata_o  = dc_done_o ? r_rdata : '0;
  assign timeout_o   = w_resp && r_timeout;
  assign busy_o      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int WIDTH = 32;
  localparam int TMO   = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             ic_req_i = 1'b0;
  logic [WIDTH-1:0] ic_addr_i = '0;
  logic             ic_done_o;
  logic [WIDTH-1:0] ic_rdata_o;
  logic             dc_req_i = 1'b0;
  logic             dc_we_i = 1'b0;
  logic [WIDTH-1:0] dc_addr_i = '0;
  logic [WIDTH-1:0] dc_wdata_i = '0;
  logic             dc_done_o;
  logic [WIDTH-1:0] dc_rdata_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic             mem_ready_i = 1'b0;
  logic [WIDTH-1:0] mem_rdata_i = '0;
  logic             timeout_o;
  logic             busy_o;

  int n_checks = 0;
  int n_errors = 0;
  bit model_last_dc = 1'b0;

  mem_arbiter #(
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ic_req_i    (ic_req_i),
    .ic_addr_i   (ic_addr_i),
    .ic_done_o   (ic_done_o),
    .ic_rdata_o  (ic_rdata_o),
    .dc_req_i    (dc_req_i),
    .dc_we_i     (dc_we_i),
    .dc_addr_i   (dc_addr_i),
    .dc_wdata_i  (dc_wdata_i),
    .dc_done_o   (dc_done_o),
    .dc_rdata_o  (dc_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .timeout_o   (timeout_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Arbitration rule: D-cache priority, or alternate on ties in round-robin mode.
  function automatic bit model_pick_dc(input bit ic, input bit dc);
    if (!dc) return 1'b0;
    if (!ic) return 1'b1;
`ifdef ARB_RR_EN
    return !model_last_dc;
`else
    return 1'b1;
`endif
  endfunction

  // lat = BUSY cycle (1-based) on which memory answers; 0 = never answers.
  task automatic run_txn(input bit ic, input bit dc, input logic [31:0] ic_a,
                         input bit we, input logic [31:0] dc_a, input logic [31:0] dc_wd,
                         input int lat, input logic [31:0] rd,
                         input bit drop_mid, input bit hold);
    bit          pick_dc;
    bit          tmo;
    int          nbusy;
    bit          exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;

    pick_dc       = model_pick_dc(ic, dc);
    model_last_dc = pick_dc;
    tmo           = (lat == 0) || (lat > TMO);
    nbusy         = tmo ? TMO : lat;
    exp_addr      = pick_dc ? dc_a : ic_a;
    exp_we        = pick_dc && we;
    exp_wd        = pick_dc ? dc_wd : 32'h0;
    exp_rd        = (tmo || exp_we) ? 32'h0 : rd;

    @(negedge clk_i);
    check_value("idle_before_req", 32'(busy_o), 32'd0);
    ic_req_i    = ic;
    ic_addr_i   = ic_a;
    dc_req_i    = dc;
    dc_we_i     = we;
    dc_addr_i   = dc_a;
    dc_wdata_i  = dc_wd;
    mem_ready_i = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom();

    for (int k = 1; k <= nbusy; k++) begin
      @(negedge clk_i);
      check_value("mem_req", 32'(mem_req_o), 32'd1);
      check_value("mem_addr", mem_addr_o, exp_addr);
      check_value("mem_we", 32'(mem_we_o), 32'(exp_we));
      check_value("mem_wdata", mem_wdata_o, exp_wd);
      check_value("done_early", 32'({ic_done_o, dc_done_o}), 32'd0);
      if (drop_mid) begin
        ic_req_i = 1'b0;
        dc_req_i = 1'b0;
      end
      mem_ready_i = (k == lat);
      mem_rdata_i = (k == lat) ? rd : $urandom();
    end

    @(negedge clk_i);
    check_value("ic_done", 32'(ic_done_o), 32'(!pick_dc));
    check_value("dc_done", 32'(dc_done_o), 32'(pick_dc));
    check_value("rdata", pick_dc ? dc_rdata_o : ic_rdata_o, exp_rd);
    check_value("timeout", 32'(timeout_o), 32'(tmo));
    check_value("mem_req_resp", 32'(mem_req_o), 32'd0);
    mem_ready_i = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom();
    if (!hold) begin
      ic_req_i = 1'b0;
      dc_req_i = 1'b0;
    end

    @(negedge clk_i);
    check_value("idle_after_resp", 32'(busy_o), 32'd0);
    check_value("single_done", 32'({ic_done_o, dc_done_o}), 32'd0);
    mem_ready_i = 1'b0;
    if (hold) begin
      ic_req_i = 1'b0;
      dc_req_i = 1'b0;
      @(negedge clk_i);
      check_value("no_regrant", 32'(mem_req_o), 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check_value("rst_mem_req", 32'(mem_req_o), 32'd0);
    check_value("rst_busy", 32'(busy_o), 32'd0);
    check_value("rst_done", 32'({ic_done_o, dc_done_o, timeout_o, mem_we_o}), 32'd0);
    check_value("rst_addr", mem_addr_o, 32'd0);
    rst_ni = 1'b1;

    // Directed scenarios
    run_txn(1, 0, 32'h100, 0, 32'h0, 32'h0, 3, 32'hDEADBEEF, 0, 0);
    run_txn(0, 1, 32'h0, 1, 32'h40, 32'h12345678, 1, 32'hCAFEF00D, 0, 0);
    run_txn(1, 1, 32'h200, 0, 32'h300, 32'h0, 2, 32'h11112222, 0, 0);
    run_txn(1, 1, 32'h204, 0, 32'h304, 32'h0, 1, 32'h33334444, 0, 0);
    run_txn(1, 0, 32'h500, 0, 32'h0, 32'h0, 0, 32'h55556666, 0, 0);
    run_txn(0, 1, 32'h0, 0, 32'h600, 32'h0, 4, 32'h77778888, 0, 0);
    run_txn(0, 1, 32'h0, 0, 32'h604, 32'h0, 5, 32'h9999AAAA, 0, 0);

    // Reset in the middle of an access
    @(negedge clk_i);
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h700;
    @(negedge clk_i);
    check_value("pre_rst_mem_req", 32'(mem_req_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check_value("rst_mid_mem_req", 32'(mem_req_o), 32'd0);
    check_value("rst_mid_busy", 32'(busy_o), 32'd0);
    ic_req_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check_value("rst_mid_no_done", 32'({ic_done_o, dc_done_o}), 32'd0);
    end
    rst_ni        = 1'b1;
    model_last_dc = 1'b0;
    run_txn(1, 1, 32'h710, 0, 32'h720, 32'h0, 2, 32'hABCD0123, 0, 0);

    // Held request through RESP, and request dropped mid-access
    run_txn(1, 0, 32'h800, 0, 32'h0, 32'h0, 2, 32'h0BADF00D, 0, 1);
    run_txn(0, 1, 32'h0, 0, 32'h900, 32'h0, 3, 32'h12121212, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit ic;
      bit dc;
      ic = 1'($urandom_range(0, 1));
      dc = ic ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(ic, dc, $urandom(), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
              int'($urandom_range(0, 6)), $urandom(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
